// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// types -- shared type definitions for the decode/execute pipeline boundary.
//
// Holds the ALU operation enums carried from decode into the ALU and the
// ID/EX stage state enum.  All enums have a zero-valued first member, so a
// cleared register holds the "default" operation (aluop_ari, comp_eq, ...).
//
// Also provides src_match(), the common "does this producer write the register
// this consumer reads" test used by both forwarding and hazard detection.
// -----------------------------------------------------------------------------
package types;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    comp_eq  = 3'd0,
    comp_ne  = 3'd1,
    comp_lt  = 3'd2,
    comp_ge  = 3'd3,
    comp_ltu = 3'd4,
    comp_geu = 3'd5
  } compop_t;

  typedef enum logic [1:0] {
    arith_add  = 2'd0,
    arith_sub  = 2'd1,
    arith_slt  = 2'd2,
    arith_sltu = 2'd3
  } arithop_t;

  typedef enum logic [1:0] {
    logic_and = 2'd0,
    logic_or  = 2'd1,
    logic_xor = 2'd2,
    logic_nor = 2'd3
  } logicop_t;

  typedef enum logic [1:0] {
    div_div  = 2'd0,
    div_divu = 2'd1,
    div_rem  = 2'd2,
    div_remu = 2'd3
  } divop_t;

  typedef enum logic [1:0] {
    mul_mul    = 2'd0,
    mul_mulh   = 2'd1,
    mul_mulhsu = 2'd2,
    mul_mulhu  = 2'd3
  } mulop_t;

  typedef enum logic [2:0] {
    aluop_ari = 3'd0,
    aluop_log = 3'd1,
    aluop_cmp = 3'd2,
    aluop_mul = 3'd3,
    aluop_div = 3'd4,
    aluop_shf = 3'd5
  } aluop_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } id_ex_state;

  // A producer only counts if it really writes, and never for x0.
  function automatic logic src_match(input logic [REG_IDX_W-1:0] rs,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic                 reg_write);
    return reg_write && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit -- operand bypass mux for one source register.
//
// Ports:
//   rs_addr                         source register index
//   rf_data                         register-file read data
//   exmem_rd/_reg_write/_data       EX/MEM producer (youngest, wins)
//   memwb_rd/_reg_write/_data       MEM/WB producer
//   data                            resolved operand (x0 always reads 0)
// -----------------------------------------------------------------------------
module forward_unit
  import types::*;
#(
  parameter int N = 32
) (
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [N-1:0]         rf_data,
  input  logic [REG_IDX_W-1:0] exmem_rd,
  input  logic                 exmem_reg_write,
  input  logic [N-1:0]         exmem_data,
  input  logic [REG_IDX_W-1:0] memwb_rd,
  input  logic                 memwb_reg_write,
  input  logic [N-1:0]         memwb_data,
  output logic [N-1:0]         data
);

  always_comb begin
    data = rf_data;
    if (rs_addr == '0) begin
      data = '0;
    end else if (src_match(rs_addr, exmem_rd, exmem_reg_write)) begin
      data = exmem_data;
    end else if (src_match(rs_addr, memwb_rd, memwb_reg_write)) begin
      data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with hazard control.
//
// Captures a decoded instruction every cycle and presents its operands and op
// fields to the ALU one cycle later.  A RUN/HOLD FSM freezes the register
// while the ALU is busy (multi-cycle mul/div); load-use hazards insert a
// bubble and back-pressure decode via o_stall_id.  i_flush kills whatever is
// held or arriving and overrides both hold and capture.
//
// Build option: FORWARDING_EN
//   defined   -> operands are bypassed from EX/MEM (priority) and MEM/WB.
//   undefined -> no bypass; any used source still in flight (ID/EX, EX/MEM,
//                MEM/WB) stalls decode and bubbles until it has retired.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid, i_rs*/i_rd addr     decoded instruction and register indices
//   i_rs1_data, i_rs2_data       register-file read data
//   i_imm, i_use_imm             immediate and operand-B select
//   i_reg_write, i_is_load       instruction flags
//   i_*op                        ALU op fields
//   i_exmem_*, i_memwb_*         downstream producers (forward / hazard)
//   i_flush, i_alu_stall         kill request, ALU busy
//   o_en, o_data_a/b, o_store    ALU enable and operands
//   o_*op, o_valid, o_rd_addr,
//   o_reg_write, o_is_load       registered instruction
//   o_stall_id                   combinational back-pressure to decode
// -----------------------------------------------------------------------------
module id_ex_stage
  import types::*;
#(
  parameter int N = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [REG_IDX_W-1:0] i_rs1_addr,
  input  logic [REG_IDX_W-1:0] i_rs2_addr,
  input  logic [REG_IDX_W-1:0] i_rd_addr,
  input  logic [N-1:0]         i_rs1_data,
  input  logic [N-1:0]         i_rs2_data,
  input  logic [N-1:0]         i_imm,
  input  logic                 i_use_imm,
  input  logic                 i_reg_write,
  input  logic                 i_is_load,
  input  compop_t              i_compop,
  input  arithop_t             i_arithop,
  input  logicop_t             i_logicop,
  input  divop_t               i_divop,
  input  mulop_t               i_mulop,
  input  aluop_t               i_aluop,
  input  logic [REG_IDX_W-1:0] i_exmem_rd,
  input  logic                 i_exmem_reg_write,
  input  logic [N-1:0]         i_exmem_data,
  input  logic [REG_IDX_W-1:0] i_memwb_rd,
  input  logic                 i_memwb_reg_write,
  input  logic [N-1:0]         i_memwb_data,
  input  logic                 i_flush,
  input  logic                 i_alu_stall,
  output logic                 o_en,
  output logic [N-1:0]         o_data_a,
  output logic [N-1:0]         o_data_b,
  output logic [N-1:0]         o_store_data,
  output compop_t              o_compop,
  output arithop_t             o_arithop,
  output logic                 o_valid,
  output logic [REG_IDX_W-1:0] o_rd_addr,
  output logic                 o_reg_write,
  output logic                 o_is_load,
  output logic                 o_stall_id,
  output logicop_t             o_logicop,
  output divop_t               o_divop,
  output mulop_t               o_mulop,
  output aluop_t               o_aluop
);

  id_ex_state state_reg, state_next;

  logic [REG_IDX_W-1:0] rs_addr [2];
  logic [N-1:0]         rs_data [2];
  logic [N-1:0]         rs_fwd  [2];

  logic rs2_used;
  logic load_use;
  logic raw_hazard;
  logic hazard;
  logic stall;
  logic do_capture;
  logic do_bubble;

  assign rs_addr[0] = i_rs1_addr;
  assign rs_addr[1] = i_rs2_addr;
  assign rs_data[0] = i_rs1_data;
  assign rs_data[1] = i_rs2_data;

  // An immediate replaces rs2 as operand B, but stores still read rs2 as data.
  assign rs2_used = !i_use_imm || !i_reg_write;

  // The load in ID/EX has no data until MEM, so even bypass cannot help.
  assign load_use = i_valid && o_valid && o_is_load && (o_rd_addr != '0) &&
                    ((o_rd_addr == i_rs1_addr) ||
                     (rs2_used && (o_rd_addr == i_rs2_addr)));

`ifdef FORWARDING_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit #(.N(N)) u_forward (
        .rs_addr         (rs_addr[gi]),
        .rf_data         (rs_data[gi]),
        .exmem_rd        (i_exmem_rd),
        .exmem_reg_write (i_exmem_reg_write),
        .exmem_data      (i_exmem_data),
        .memwb_rd        (i_memwb_rd),
        .memwb_reg_write (i_memwb_reg_write),
        .memwb_data      (i_memwb_data),
        .data            (rs_fwd[gi])
      );
    end
  endgenerate

  assign raw_hazard = 1'b0;
`else
  // Without bypass every in-flight writer of a used source must drain first.
  logic busy [2];
  logic unused_fwd_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nofwd
      assign rs_fwd[gi] = (rs_addr[gi] == '0) ? '0 : rs_data[gi];
      assign busy[gi]   = src_match(rs_addr[gi], o_rd_addr, o_valid && o_reg_write) ||
                          src_match(rs_addr[gi], i_exmem_rd, i_exmem_reg_write) ||
                          src_match(rs_addr[gi], i_memwb_rd, i_memwb_reg_write);
    end
  endgenerate

  assign raw_hazard      = i_valid && (busy[0] || (rs2_used && busy[1]));
  assign unused_fwd_data = ^{i_exmem_data, i_memwb_data};
`endif

  assign hazard = load_use || raw_hazard;

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    do_capture = 1'b0;
    do_bubble  = 1'b0;
    case (state_reg)
      RUN: begin
        // The ALU owns the current operands while busy; hold takes precedence
        // over any hazard on the instruction waiting behind it.
        if (o_valid && i_alu_stall) begin
          state_next = HOLD;
          stall      = 1'b1;
        end else if (hazard) begin
          stall     = 1'b1;
          do_bubble = 1'b1;
        end else begin
          do_capture = 1'b1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (!i_alu_stall) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    // Killed instructions free decode immediately, whatever else is pending.
    if (i_flush) begin
      state_next = RUN;
      stall      = 1'b0;
      do_capture = 1'b0;
      do_bubble  = 1'b0;
    end
  end

  assign o_stall_id = stall;
  assign o_en       = o_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= RUN;
      o_valid      <= 1'b0;
      o_reg_write  <= 1'b0;
      o_is_load    <= 1'b0;
      o_rd_addr    <= '0;
      o_data_a     <= '0;
      o_data_b     <= '0;
      o_store_data <= '0;
      o_compop     <= comp_eq;
      o_arithop    <= arith_add;
      o_logicop    <= logic_and;
      o_divop      <= div_div;
      o_mulop      <= mul_mul;
      o_aluop      <= aluop_ari;
    end else begin
      state_reg <= state_next;
      if (i_flush || do_bubble) begin
        o_valid     <= 1'b0;
        o_reg_write <= 1'b0;
        o_is_load   <= 1'b0;
      end else if (do_capture) begin
        o_valid      <= i_valid;
        o_reg_write  <= i_valid && i_reg_write;
        o_is_load    <= i_valid && i_is_load;
        o_rd_addr    <= i_rd_addr;
        o_data_a     <= rs_fwd[0];
        o_data_b     <= i_use_imm ? i_imm : rs_fwd[1];
        o_store_data <= rs_fwd[1];
        o_compop     <= i_compop;
        o_arithop    <= i_arithop;
        o_logicop    <= i_logicop;
        o_divop      <= i_divop;
        o_mulop      <= i_mulop;
        o_aluop      <= i_aluop;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage -- directed bench for id_ex_stage.  Expectations for the
// bypass-dependent cases follow FORWARDING_EN.  A small EX/MEM -> MEM/WB model
// can replace the manually driven producer ports for the drain-timing cases.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  import types::*;

  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rst, i_valid, i_use_imm, i_reg_write, i_is_load;
  logic [4:0]     i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic [N-1:0]   i_rs1_data, i_rs2_data, i_imm;
  compop_t        i_compop;
  arithop_t       i_arithop;
  logicop_t       i_logicop;
  divop_t         i_divop;
  mulop_t         i_mulop;
  aluop_t         i_aluop;
  logic [4:0]     i_exmem_rd, i_memwb_rd;
  logic           i_exmem_reg_write, i_memwb_reg_write;
  logic [N-1:0]   i_exmem_data, i_memwb_data;
  logic           i_flush, i_alu_stall;
  logic           o_en, o_valid, o_reg_write, o_is_load, o_stall_id;
  logic [N-1:0]   o_data_a, o_data_b, o_store_data;
  logic [4:0]     o_rd_addr;
  compop_t        o_compop;
  arithop_t       o_arithop;
  logicop_t       o_logicop;
  divop_t         o_divop;
  mulop_t         o_mulop;
  aluop_t         o_aluop;

  // Producer ports: manual values or the downstream pipeline model.
  logic           auto_pipe;
  logic [4:0]     man_exmem_rd, man_memwb_rd, p_exmem_rd, p_memwb_rd;
  logic           man_exmem_rw, man_memwb_rw, p_exmem_rw, p_memwb_rw;
  logic [N-1:0]   man_exmem_data, man_memwb_data;

  assign i_exmem_rd        = auto_pipe ? p_exmem_rd : man_exmem_rd;
  assign i_exmem_reg_write = auto_pipe ? p_exmem_rw : man_exmem_rw;
  assign i_exmem_data      = auto_pipe ? '0 : man_exmem_data;
  assign i_memwb_rd        = auto_pipe ? p_memwb_rd : man_memwb_rd;
  assign i_memwb_reg_write = auto_pipe ? p_memwb_rw : man_memwb_rw;
  assign i_memwb_data      = auto_pipe ? '0 : man_memwb_data;

  always @(posedge clk) begin
    if (i_rst) begin
      p_exmem_rd <= '0; p_exmem_rw <= 1'b0;
      p_memwb_rd <= '0; p_memwb_rw <= 1'b0;
    end else begin
      p_exmem_rd <= o_rd_addr;
      p_exmem_rw <= o_valid && o_reg_write && !i_alu_stall;
      p_memwb_rd <= p_exmem_rd;
      p_memwb_rw <= p_exmem_rw;
    end
  end

  id_ex_stage #(.N(N)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_use_imm(i_use_imm),
    .i_reg_write(i_reg_write), .i_is_load(i_is_load),
    .i_compop(i_compop), .i_arithop(i_arithop), .i_logicop(i_logicop),
    .i_divop(i_divop), .i_mulop(i_mulop), .i_aluop(i_aluop),
    .i_exmem_rd(i_exmem_rd), .i_exmem_reg_write(i_exmem_reg_write),
    .i_exmem_data(i_exmem_data),
    .i_memwb_rd(i_memwb_rd), .i_memwb_reg_write(i_memwb_reg_write),
    .i_memwb_data(i_memwb_data),
    .i_flush(i_flush), .i_alu_stall(i_alu_stall),
    .o_en(o_en), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_store_data(o_store_data), .o_compop(o_compop), .o_arithop(o_arithop),
    .o_valid(o_valid), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
    .o_is_load(o_is_load), .o_stall_id(o_stall_id),
    .o_logicop(o_logicop), .o_divop(o_divop), .o_mulop(o_mulop),
    .o_aluop(o_aluop)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [N-1:0] d1,
                           input logic [N-1:0] d2, input logic [N-1:0] imm,
                           input logic use_imm, input logic rw, input logic ld,
                           input aluop_t op);
    i_valid = 1'b1;
    i_rs1_addr = rs1; i_rs2_addr = rs2; i_rd_addr = rd;
    i_rs1_data = d1; i_rs2_data = d2; i_imm = imm;
    i_use_imm = use_imm; i_reg_write = rw; i_is_load = ld;
    i_aluop = op; i_arithop = arith_add;
  endtask

  task automatic clear_man();
    man_exmem_rd = '0; man_exmem_rw = 1'b0; man_exmem_data = '0;
    man_memwb_rd = '0; man_memwb_rw = 1'b0; man_memwb_data = '0;
  endtask

  // Counts cycles decode is stalled, then lets the instruction in (bounded).
  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!o_stall_id) break;
      n++;
      tick();
    end
    tick();
  endtask

  int n_stall;
  int bad;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_alu_stall = 1'b0;
    i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_use_imm = 1'b0; i_reg_write = 1'b0; i_is_load = 1'b0;
    i_compop = comp_lt; i_arithop = arith_add; i_logicop = logic_and;
    i_divop = div_div; i_mulop = mul_mul; i_aluop = aluop_ari;
    auto_pipe = 1'b0;
    clear_man();
    tick(); tick();
    check_val("rst_valid", o_valid, 0);
    check_val("rst_en", o_en, 0);
    check_val("rst_regwr", o_reg_write, 0);
    check_val("rst_data_a", o_data_a, 0);
    check_val("rst_aluop", o_aluop, aluop_ari);
    check_val("rst_stall", o_stall_id, 0);
    i_rst = 1'b0;

    // Basic capture with immediate operand B.
    set_instr(5'd3, 5'd6, 5'd4, 32'h111, 32'h666, 32'h55, 1, 1, 0, aluop_log);
    i_logicop = logic_xor;
    #1 check_val("t1_stall", o_stall_id, 0);
    tick();
    check_val("t1_valid", o_valid, 1);
    check_val("t1_en", o_en, 1);
    check_val("t1_data_a", o_data_a, 32'h111);
    check_val("t1_data_b", o_data_b, 32'h55);
    check_val("t1_store", o_store_data, 32'h666);
    check_val("t1_rd", o_rd_addr, 4);
    check_val("t1_logicop", o_logicop, logic_xor);

    // EX/MEM and MEM/WB both hold x1.
    man_exmem_rd = 5'd1; man_exmem_rw = 1'b1; man_exmem_data = 32'h10;
    man_memwb_rd = 5'd1; man_memwb_rw = 1'b1; man_memwb_data = 32'h20;
    set_instr(5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'h0, 0, 1, 0, aluop_ari);
`ifdef FORWARDING_EN
    #1 check_val("fw_pri_stall", o_stall_id, 0);
    tick();
    check_val("fw_pri_a", o_data_a, 32'h10);
    check_val("fw_pri_b", o_data_b, 32'hBBBB);
`else
    #1 check_val("nf_pri_stall", o_stall_id, 1);
    tick();
    check_val("nf_pri_bubble", o_valid, 0);
    clear_man();
    #1 check_val("nf_pri_clear", o_stall_id, 0);
    tick();
    check_val("nf_pri_a", o_data_a, 32'hAAAA);
`endif

    // MEM/WB only; EX/MEM names x2 but does not write.
    man_exmem_rd = 5'd2; man_exmem_rw = 1'b0; man_exmem_data = 32'h10;
    man_memwb_rd = 5'd2; man_memwb_rw = 1'b1; man_memwb_data = 32'h20;
    set_instr(5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'h0, 0, 1, 0, aluop_ari);
`ifdef FORWARDING_EN
    tick();
    check_val("fw_wb_a", o_data_a, 32'hAAAA);
    check_val("fw_wb_b", o_data_b, 32'h20);
    check_val("fw_wb_store", o_store_data, 32'h20);
`else
    #1 check_val("nf_wb_stall", o_stall_id, 1);
    tick();
    clear_man();
    tick();
    check_val("nf_wb_b", o_data_b, 32'hBBBB);
`endif
    clear_man();

    // x0 source never forwards, even from a writing rd=0 producer.
    man_exmem_rd = 5'd0; man_exmem_rw = 1'b1; man_exmem_data = 32'hDEAD;
    set_instr(5'd0, 5'd5, 5'd10, 32'h1234, 32'h55, 32'h0, 0, 1, 0, aluop_ari);
    #1 check_val("x0_stall", o_stall_id, 0);
    tick();
    check_val("x0_data_a", o_data_a, 0);
    check_val("x0_data_b", o_data_b, 32'h55);
    clear_man();

    // Store after load reads rs2 despite the immediate.
    set_instr(5'd9, 5'd0, 5'd4, 32'h1000, 32'h0, 32'h8, 1, 1, 1, aluop_ari);
    tick();
    check_val("lw_is_load", o_is_load, 1);
    set_instr(5'd9, 5'd4, 5'd0, 32'h1000, 32'h4444, 32'h4, 1, 0, 0, aluop_ari);
    #1 check_val("sw_lu_stall", o_stall_id, 1);
    tick();
    check_val("sw_bubble_valid", o_valid, 0);
    check_val("sw_bubble_en", o_en, 0);
    #1 check_val("sw_resume", o_stall_id, 0);
    tick();
    check_val("sw_store", o_store_data, 32'h4444);
    check_val("sw_data_b", o_data_b, 32'h4);
    check_val("sw_regwr", o_reg_write, 0);
    // ADDI whose rs2 field names the load target: rs2 unused, no stall.
    set_instr(5'd9, 5'd0, 5'd4, 32'h1000, 32'h0, 32'h8, 1, 1, 1, aluop_ari);
    tick();
    set_instr(5'd9, 5'd4, 5'd11, 32'h1000, 32'h0, 32'h3, 1, 1, 0, aluop_ari);
    #1 check_val("addi_nostall", o_stall_id, 0);
    tick();
    check_val("addi_rd", o_rd_addr, 11);
    // Load to x0 never creates a hazard.
    set_instr(5'd9, 5'd0, 5'd0, 32'h1000, 32'h0, 32'h8, 1, 1, 1, aluop_ari);
    tick();
    set_instr(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 0, 1, 0, aluop_ari);
    #1 check_val("ldx0_nostall", o_stall_id, 0);
    tick();

    // Flush wins over a load-use hazard.
    set_instr(5'd9, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, 1, 1, 1, aluop_ari);
    tick();
    set_instr(5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 0, 1, 0, aluop_ari);
    i_flush = 1'b1;
    #1 check_val("flush_hz_stall", o_stall_id, 0);
    tick();
    check_val("flush_valid", o_valid, 0);
    check_val("flush_en", o_en, 0);
    check_val("flush_regwr", o_reg_write, 0);
    i_flush = 1'b0;

    // DIV held for 33 busy cycles.
    set_instr(5'd12, 5'd13, 5'd11, 32'h100, 32'h7, 32'h0, 0, 1, 0, aluop_div);
    i_divop = div_rem;
    tick();
    check_val("div_aluop", o_aluop, aluop_div);
    set_instr(5'd15, 5'd16, 5'd14, 32'h1500, 32'h1600, 32'h0, 0, 1, 0, aluop_ari);
    i_alu_stall = 1'b1;
    bad = 0;
    repeat (33) begin
      #1;
      if (o_stall_id !== 1'b1 || o_en !== 1'b1 || o_data_a !== 32'h100 ||
          o_rd_addr !== 5'd11 || o_divop !== div_rem) bad++;
      tick();
    end
    check_val("hold_bad_cycles", bad, 0);
    i_alu_stall = 1'b0;
    #1 check_val("hold_exit_stall", o_stall_id, 1);
    check_val("hold_exit_rd", o_rd_addr, 11);
    tick();
    check_val("run_stall", o_stall_id, 0);
    tick();
    check_val("after_hold_rd", o_rd_addr, 14);
    check_val("after_hold_a", o_data_a, 32'h1500);

    // Flush during HOLD, then reset during HOLD.
    set_instr(5'd12, 5'd13, 5'd11, 32'h100, 32'h7, 32'h0, 0, 1, 0, aluop_div);
    tick();
    set_instr(5'd15, 5'd16, 5'd14, 32'h1500, 32'h1600, 32'h0, 0, 1, 0, aluop_ari);
    i_alu_stall = 1'b1;
    tick(); tick(); tick();
    i_flush = 1'b1;
    #1 check_val("hflush_stall", o_stall_id, 0);
    tick();
    check_val("hflush_valid", o_valid, 0);
    check_val("hflush_en", o_en, 0);
    i_flush = 1'b0;
    #1 check_val("hflush_run", o_stall_id, 0);
    tick();
    check_val("hflush_cap_rd", o_rd_addr, 14);
    #1 check_val("rehold_stall", o_stall_id, 1);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    check_val("hrst_valid", o_valid, 0);
    check_val("hrst_en", o_en, 0);
    check_val("hrst_data_a", o_data_a, 0);
    check_val("hrst_rd", o_rd_addr, 0);
    i_rst = 1'b0; i_alu_stall = 1'b0; i_valid = 1'b0;
    #1 check_val("hrst_state_run", o_stall_id, 0);

    // Drain timing with the downstream pipeline model.
    auto_pipe = 1'b1;
    tick(); tick(); tick();
    set_instr(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h0, 0, 1, 0, aluop_ari);
    tick();
    set_instr(5'd7, 5'd1, 5'd8, 32'h7, 32'h1, 32'h0, 0, 1, 0, aluop_ari);
    i_arithop = arith_sub;
    count_stalls(n_stall);
`ifdef FORWARDING_EN
    check_val("raw_stalls", n_stall, 0);
`else
    check_val("raw_stalls", n_stall, 3);
`endif
    check_val("raw_rd", o_rd_addr, 8);
    check_val("raw_arithop", o_arithop, arith_sub);
    i_valid = 1'b0;
    tick(); tick(); tick();

    set_instr(5'd9, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, 1, 1, 1, aluop_ari);
    tick();
    set_instr(5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 0, 1, 0, aluop_ari);
    count_stalls(n_stall);
`ifdef FORWARDING_EN
    check_val("lu_stalls", n_stall, 1);
`else
    check_val("lu_stalls", n_stall, 3);
`endif
    check_val("lu_rd", o_rd_addr, 6);
    check_val("lu_valid", o_valid, 1);
    i_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits.
REQ-002 SHALL have i_clk  input  1  single clock, rising edge.
REQ-003 SHALL have i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have i_valid  input  1  decode presents an instruction.
REQ-005 SHALL have i_rs1_addr, i_rs2_addr, i_rd_addr  input  5 each  source/destination indices.
REQ-006 SHALL have i_rs1_data, i_rs2_data  input  N each  register-file read data.
REQ-007 SHALL have i_imm  input  N  immediate; i_use_imm  input  1  selects i_imm as operand B.
REQ-008 SHALL have i_reg_write, i_is_load  input  1 each  instruction flags.
REQ-009 SHALL have i_compop, i_arithop, i_logicop, i_divop, i_mulop, i_aluop  input  package enums  ALU op fields.
REQ-010 SHALL have i_exmem_rd  input  5, i_exmem_reg_write  input  1, i_exmem_data  input  N  EX/MEM forward source.
REQ-011 SHALL have i_memwb_rd  input  5, i_memwb_reg_write  input  1, i_memwb_data  input  N  MEM/WB forward source.
REQ-012 SHALL have i_flush  input  1  kill instruction held or arriving; i_alu_stall  input  1  ALU busy.
REQ-013 SHALL have o_en  output  1  ALU enable; o_data_a, o_data_b, o_store_data  output  N each  operands.
REQ-014 SHALL have o_compop..o_aluop  output  enums, o_valid, o_rd_addr, o_reg_write, o_is_load  output  registered copies.
REQ-015 SHALL have o_stall_id  output  1  combinational backpressure to decode.

Function
REQ-016 SHALL implement FSM states RUN and HOLD; RUN->HOLD when o_valid && i_alu_stall; HOLD->RUN when !i_alu_stall.
REQ-017 In HOLD all output registers SHALL keep their values and o_stall_id SHALL be 1.
REQ-018 o_en SHALL equal o_valid in both states (ALU stays enabled through multi-cycle mul/div).
REQ-019 Load-use hazard: o_valid && o_is_load && o_rd_addr!=0 && o_rd_addr matches a used rs of incoming valid instruction SHALL raise o_stall_id and load a bubble (o_valid=0, o_reg_write=0).
REQ-020 rs2 is "used" only when !i_use_imm or instruction is a store (i_reg_write=0); rs1 always used.
REQ-021 In RUN without stall, capture SHALL occur every cycle; latency decode->ALU operands = 1 cycle.
REQ-022 Forwarding SHALL apply to i_rs1_data/i_rs2_data at capture: EX/MEM match wins over MEM/WB; otherwise register-file data.
REQ-023 A source SHALL match only if its reg_write=1 and rd!=0; index 0 SHALL always yield 0.
REQ-024 o_data_b SHALL be i_imm when i_use_imm, else forwarded rs2; o_store_data SHALL always be forwarded rs2.
REQ-025 i_flush SHALL have priority over hold and capture: next cycle o_valid=0, o_en=0, o_reg_write=0, state RUN.
REQ-026 Flush with simultaneous hazard SHALL clear o_stall_id in the same cycle.

Reset
REQ-027 On i_rst at a clock edge: state RUN, o_valid=0, o_en=0, o_reg_write=0, o_is_load=0, o_rd_addr=0, data outputs 0, op fields to their package default (aluop_ari, zero-valued enums).
REQ-028 Reset SHALL take effect mid-HOLD; o_en drops so the ALU aborts its operation.

Configuration
REQ-029 Macro FORWARDING_EN defined: forwarding per REQ-022..023 compiled in.
REQ-030 Macro FORWARDING_EN undefined: no forwarding muxes; any match of a used rs against o_rd_addr, i_exmem_rd or i_memwb_rd (reg_write=1, rd!=0) SHALL stall and bubble until clear.

Structure
REQ-031 State enum (id_ex_state: RUN, HOLD) SHALL live in package types beside the existing ALU op enums.
REQ-032 Forwarding mux SHALL be one sub-module forward_unit (instantiated twice, rs1/rs2); hazard logic stays inline.

Verification
REQ-033 ADD x3=x1+x2, EX/MEM rd=1 data 0x10, MEM/WB rd=1 data 0x20 -> o_data_a=0x10 (EX/MEM priority).
REQ-034 EX/MEM rd=0 reg_write=1 data 0xDEAD, instr rs1=x0 -> o_data_a=0.
REQ-035 LW x5 then ADD x6=x5+x5 -> one bubble cycle, o_stall_id=1 one cycle, ADD issues next cycle.
REQ-036 DIV valid, i_alu_stall high 33 cycles -> HOLD 33 cycles, outputs stable, o_en=1, then RUN.
REQ-037 i_flush during HOLD -> next cycle o_valid=0, o_en=0, state RUN; i_rst mid-HOLD -> same plus zeroed data.
REQ-038 FORWARDING_EN undefined, ADD x7 then SUB using x7 -> stall 3 cycles until x7 leaves MEM/WB.
